// File: rtl/vga_plot_sink.sv
// Plot-stream sink: clears a linear framebuffer after reset, then queues plots in a show-ahead FIFO for writing.
// Define PLOT_SINK_TRANSPARENT_EN to discard in-range plots whose colour equals TRANSPARENT_COLOUR.
module vga_plot_sink #(
  parameter int         X_SCREEN_PIXELS    = 320,
  parameter int         Y_SCREEN_PIXELS    = 240,
  parameter logic [2:0] BG_COLOUR          = 3'b000,
  parameter int         FIFO_DEPTH         = 8,
  parameter logic [2:0] TRANSPARENT_COLOUR = 3'b101
) (
  input  logic                                                   clk,
  input  logic                                                   iResetn,
  input  logic [$clog2(X_SCREEN_PIXELS):0]                       iX,
  input  logic [$clog2(Y_SCREEN_PIXELS):0]                       iY,
  input  logic [2:0]                                             iColour,
  input  logic                                                   iPlot,
  input  logic                                                   iNewFrame,
  output logic                                                   oReady,
  output logic [$clog2(X_SCREEN_PIXELS*Y_SCREEN_PIXELS)-1:0]     oMemAddr,
  output logic [2:0]                                             oMemData,
  output logic                                                   oMemWe,
  input  logic                                                   iMemReady,
  output logic                                                   oBusy,
  output logic [7:0]                                             oDropCount,
  output logic [7:0]                                             oClipCount,
  output logic [7:0]                                             oFrameCount
);

  localparam int XW = $clog2(X_SCREEN_PIXELS) + 1;
  localparam int YW = $clog2(Y_SCREEN_PIXELS) + 1;
  localparam int AW = $clog2(X_SCREEN_PIXELS * Y_SCREEN_PIXELS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);

`ifdef PLOT_SINK_TRANSPARENT_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
  logic [2:0]      fifo_col  [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      drop_cnt, clip_cnt, frame_cnt;

  logic            ready, not_empty, off_screen, key_hit, accept, push, pop;
  logic [AW-1:0]   plot_addr;

  assign ready      = (state == RUN) && (count != CW'(FIFO_DEPTH));
  assign not_empty  = (count != '0);
  assign off_screen = (iX >= XW'(X_SCREEN_PIXELS)) || (iY >= YW'(Y_SCREEN_PIXELS));
  assign key_hit    = (iColour == TRANSPARENT_COLOUR);
  // Both operands widened to the address width before the multiply-add.
  assign plot_addr  = AW'(iY) * AW'(X_SCREEN_PIXELS) + AW'(iX);
  assign accept     = iPlot && ready;
  assign push       = accept && !off_screen && !(KEY_EN && key_hit);
  assign pop        = (state == RUN) && not_empty && iMemReady;

  assign oReady      = ready;
  assign oBusy       = (state == CLEAR);
  assign oMemWe      = (state == CLEAR) || not_empty;
  assign oMemAddr    = (state == CLEAR) ? clr_addr  : fifo_addr[rd_ptr];
  assign oMemData    = (state == CLEAR) ? BG_COLOUR : fifo_col[rd_ptr];
  assign oDropCount  = drop_cnt;
  assign oClipCount  = clip_cnt;
  assign oFrameCount = frame_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= plot_addr;
      fifo_col[wr_ptr]  <= iColour;
    end
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      clip_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (iNewFrame)
        frame_cnt <= frame_cnt + 8'd1;
      if (iPlot && !ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (accept && off_screen && clip_cnt != 8'hFF)
        clip_cnt <= clip_cnt + 8'd1;

      case (state)
        CLEAR: begin
          if (iMemReady) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= RUN;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + AW'(1);
            end
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule
